// File: rtl/dram_cache_pkg.sv
// Shared types for the DRAM-cache request path: FIFO entry layout
// and the unpacked request carried to the tag-lookup stage.
package dram_cache_pkg;

    localparam int ENT_W      = 128;
    localparam int ENT_ID_W   = 32;
    localparam int ENT_ADDR_W = 32;
    localparam int ENT_IDX_W  = 4;
    localparam int ENT_CNT_W  = 16;

    localparam int ADDR_POS  = 0;
    localparam int ID_POS    = ADDR_POS + ENT_ADDR_W;
    localparam int WRITE_POS = ID_POS + ENT_ID_W;
    localparam int IDX_POS   = WRITE_POS + 1;
    localparam int RSVD_POS  = IDX_POS + ENT_IDX_W;
    localparam int RSVD_W    = ENT_W - RSVD_POS;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [RSVD_W-1:0]     rsvd;
        logic [ENT_IDX_W-1:0]  index;
        logic                  is_write;
        logic [ENT_ID_W-1:0]   id;
        logic [ENT_ADDR_W-1:0] addr;
    } req_entry_t;

    typedef struct packed {
        logic [ENT_ID_W-1:0]   id;
        logic [ENT_ADDR_W-1:0] addr;
        logic                  write;
        logic [ENT_IDX_W-1:0]  index;
    } req_t;

endpackage

// File: rtl/req_skid_buf2.sv
// Two-entry valid/ready buffer; head register drives the outputs
// directly so the downstream interface is fully registered.
module req_skid_buf2
    import dram_cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  req_t       in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output req_t       out_data,
    output logic [1:0] occ
);

    req_t head;
    req_t tail;
    logic deq;

    assign out_valid = (occ != OCC_EMPTY);
    assign out_data  = head;
    assign deq       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    if (in_valid) begin
                        head <= in_data;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_valid && !deq) begin
                        tail <= in_data;
                        occ  <= OCC_FULL;
                    end else if (in_valid && deq) begin
                        head <= in_data;
                    end else if (deq) begin
                        occ <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // Credit logic keeps in_valid low here unless a slot frees
                    if (deq) begin
                        head <= tail;
                        if (in_valid) begin
                            tail <= in_data;
                        end else begin
                            occ <= OCC_ONE;
                        end
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/index_fifo_reader.sv
// Drains the AR/AW request FIFO, unpacks and checks each entry and
// issues it to the tag-lookup stage with one request per cycle.
module index_fifo_reader
    import dram_cache_pkg::*;
#(
    parameter int DATA_W    = ENT_W,
    parameter int ID_W      = ENT_ID_W,
    parameter int ADDR_W    = ENT_ADDR_W,
    parameter int INDEX_W   = ENT_IDX_W,
    parameter int INDEX_LSB = 0,
    parameter int CNT_W     = ENT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty_i,
    output logic               fifo_read_en_o,
    input  logic [DATA_W-1:0]  fifo_data_i,
    output logic               req_valid_o,
    input  logic               req_ready_i,
    output logic [ID_W-1:0]    req_id_o,
    output logic [ADDR_W-1:0]  req_addr_o,
    output logic               req_write_o,
    output logic [INDEX_W-1:0] req_index_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   rd_cnt_o,
    output logic [CNT_W-1:0]   wr_cnt_o
);

    req_entry_t ent;
    req_t       cap_req;
    req_t       head;
    logic [1:0] occ;
    logic [2:0] credit;
    logic       inflight;
    logic       deq;
    logic       bad;

    assign ent = fifo_data_i;
    assign deq = req_valid_o && req_ready_i;

    // Slots committed next cycle: buffered plus in flight, minus leaving
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, deq};
    assign fifo_read_en_o = !rst && !fifo_empty_i && (credit < 3'd2);

    assign cap_req.id    = ent.id;
    assign cap_req.addr  = ent.addr;
    assign cap_req.write = ent.is_write;
    assign cap_req.index = ent.index;

    assign bad = (|ent.rsvd) ||
                 (ent.index != ent.addr[INDEX_LSB +: INDEX_W]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_read_en_o;
        end
    end

    req_skid_buf2 u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight),
        .in_data   (cap_req),
        .out_valid (req_valid_o),
        .out_ready (req_ready_i),
        .out_data  (head),
        .occ       (occ)
    );

    assign req_id_o    = head.id;
    assign req_addr_o  = head.addr;
    assign req_write_o = head.write;
    assign req_index_o = head.index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (inflight && bad) begin
            err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (deq) begin
            if (req_write_o) begin
                wr_cnt_o <= wr_cnt_o + CNT_W'(1);
            end else begin
                rd_cnt_o <= rd_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_index_fifo_reader.sv
// Directed and randomized bench for index_fifo_reader with a queue
// based FIFO model and in-order request scoreboard.
module tb_index_fifo_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty_i;
    logic         fifo_read_en_o;
    logic [127:0] fifo_data_i;
    logic         req_valid_o;
    logic         req_ready_i;
    logic [31:0]  req_id_o;
    logic [31:0]  req_addr_o;
    logic         req_write_o;
    logic [3:0]   req_index_o;
    logic         err_o;
    logic [15:0]  rd_cnt_o;
    logic [15:0]  wr_cnt_o;

    index_fifo_reader dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty_i   (fifo_empty_i),
        .fifo_read_en_o (fifo_read_en_o),
        .fifo_data_i    (fifo_data_i),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .req_id_o       (req_id_o),
        .req_addr_o     (req_addr_o),
        .req_write_o    (req_write_o),
        .req_index_o    (req_index_o),
        .err_o          (err_o),
        .rd_cnt_o       (rd_cnt_o),
        .wr_cnt_o       (wr_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [127:0] fifo_q[$];
    logic [127:0] exp_q[$];
    logic [15:0]  m_rd;
    logic [15:0]  m_wr;
    logic         m_err;

    logic         s_re;
    logic         s_valid;
    logic         s_err;
    logic [68:0]  s_req;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic malformed(input logic [127:0] e);
        return (e[127:69] != '0) || (e[68:65] != e[3:0]);
    endfunction

    function automatic logic [68:0] unpack(input logic [127:0] e);
        return {e[63:32], e[31:0], e[64], e[68:65]};
    endfunction

    function automatic logic [127:0] mk(input logic [31:0] addr,
                                        input logic [31:0] id,
                                        input logic w,
                                        input logic [3:0] idx,
                                        input logic [58:0] rsvd);
        return {rsvd, idx, w, id, addr};
    endfunction

    function automatic logic [127:0] rnd_entry(input bit allow_bad);
        logic [31:0] a;
        logic [3:0]  idx;
        logic [58:0] rs;
        a   = $urandom;
        idx = a[3:0];
        rs  = '0;
        if (allow_bad && ($urandom % 8 == 0)) begin
            if ($urandom % 2 == 0) idx = idx ^ 4'(1 + $urandom % 15);
            else rs[$urandom % 59] = 1'b1;
        end
        return mk(a, $urandom, 1'($urandom % 2), idx, rs);
    endfunction

    task automatic push(input logic [127:0] e);
        fifo_q.push_back(e);
        exp_q.push_back(e);
        fifo_empty_i = 1'b0;
    endtask

    task automatic tick();
        logic [127:0] e;
        #1;
        s_re    = fifo_read_en_o;
        s_valid = req_valid_o;
        s_err   = err_o;
        s_req   = {req_id_o, req_addr_o, req_write_o, req_index_o};
        if (fifo_empty_i) chk("no_pop_when_empty", fifo_read_en_o, 0);
        if (req_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", req_valid_o, 0);
            end else begin
                e = exp_q[0];
                chk("req_fields", s_req, unpack(e));
                if (req_ready_i) begin
                    void'(exp_q.pop_front());
                    if (e[64]) m_wr++;
                    else m_rd++;
                    if (malformed(e)) m_err = 1'b1;
                    if (m_err) chk("err_at_issue", err_o, 1);
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_re && fifo_q.size() > 0) fifo_data_i = fifo_q.pop_front();
        fifo_empty_i = (fifo_q.size() == 0);
        @(negedge clk);
        chk("rd_cnt", rd_cnt_o, m_rd);
        chk("wr_cnt", wr_cnt_o, m_wr);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && exp_q.size() > 0; i++) tick();
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        int          run;
        int          maxrun;
        int          nv;
        int          npop;
        logic [15:0] base;
        logic [31:0] sum0;

        rst = 1'b1;
        fifo_empty_i = 1'b1;
        fifo_data_i = '0;
        req_ready_i = 1'b0;
        m_rd = '0;
        m_wr = '0;
        m_err = 1'b0;
        @(negedge clk);

        push(rnd_entry(0));
        push(rnd_entry(0));
        repeat (3) begin
            tick();
            chk("rst_read_en", s_re, 0);
            chk("rst_valid", s_valid, 0);
            chk("rst_err", s_err, 0);
        end
        rst = 1'b0;
        req_ready_i = 1'b1;
        drain(10);

        req_ready_i = 1'b0;
        base = m_rd;
        push(mk(32'h2A, 32'd3, 1'b0, 4'hA, '0));
        tick();
        chk("single_pop_N", s_re, 1);
        tick();
        chk("single_valid_N1", s_valid, 0);
        req_ready_i = 1'b1;
        tick();
        chk("single_valid_N2", s_valid, 1);
        chk("single_fields", s_req, {32'd3, 32'h2A, 1'b0, 4'hA});
        chk("single_rd_cnt", rd_cnt_o, base + 16'd1);

        sum0 = 32'(m_rd) + 32'(m_wr);
        repeat (5) push(rnd_entry(0));
        run = 0;
        maxrun = 0;
        nv = 0;
        repeat (12) begin
            tick();
            if (s_valid) begin
                run++;
                nv++;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
        end
        chk("b2b_valid_cycles", nv, 5);
        chk("b2b_consecutive", maxrun, 5);
        chk("b2b_total", 32'(rd_cnt_o) + 32'(wr_cnt_o), sum0 + 5);

        req_ready_i = 1'b0;
        repeat (4) push(rnd_entry(0));
        npop = 0;
        repeat (10) begin
            tick();
            if (s_re) npop++;
        end
        chk("bp_pops", npop, 2);
        chk("bp_valid_held", s_valid, 1);
        req_ready_i = 1'b1;
        drain(12);
        chk("bp_fifo_empty", fifo_q.size(), 0);

        req_ready_i = 1'b0;
        push(mk(32'h13, 32'd7, 1'b1, 4'h5, '0));
        s_valid = 1'b0;
        for (int i = 0; i < 6 && !s_valid; i++) tick();
        chk("mal_valid_seen", s_valid, 1);
        chk("mal_err_with_valid", s_err, 1);
        chk("mal_fields", s_req, {32'd7, 32'h13, 1'b1, 4'h5});
        req_ready_i = 1'b1;
        tick();
        repeat (3) push(rnd_entry(0));
        drain(10);
        chk("mal_err_sticky", err_o, 1);

        req_ready_i = 1'b0;
        repeat (4) push(rnd_entry(0));
        repeat (3) tick();
        req_ready_i = 1'b1;
        #2;
        chk("mid_pop_pending", fifo_read_en_o, 1);
        chk("mid_full_valid", req_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", req_valid_o, 0);
        chk("arst_read_en", fifo_read_en_o, 0);
        chk("arst_fields",
            {req_id_o, req_addr_o, req_write_o, req_index_o}, 0);
        chk("arst_err", err_o, 0);
        chk("arst_cnt", {rd_cnt_o, wr_cnt_o}, 0);
        fifo_q.delete();
        exp_q.delete();
        fifo_empty_i = 1'b1;
        m_rd = '0;
        m_wr = '0;
        m_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("post_rst_idle", s_valid, 0);
        end
        push(rnd_entry(0));
        drain(6);

        repeat (300) begin
            if ($urandom % 2 == 0) push(rnd_entry(1));
            req_ready_i = ($urandom % 4 != 0);
            tick();
        end
        req_ready_i = 1'b1;
        drain(400);
        chk("final_err", err_o, m_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
